// File: rtl/shell_axil_pkg.sv
// Shared AXI4-Lite definitions for the zedboard shell register responders:
// response codes, FSM state types and the byte-strobe merge helper.
package shell_axil_pkg;

    localparam int AXIL_DATA_W = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    function automatic logic [AXIL_DATA_W-1:0] apply_wstrb(
        input logic [AXIL_DATA_W-1:0]   old_word,
        input logic [AXIL_DATA_W-1:0]   new_word,
        input logic [AXIL_DATA_W/8-1:0] strb
    );
        logic [AXIL_DATA_W-1:0] merged;
        for (int b = 0; b < AXIL_DATA_W/8; b++) begin
            merged[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register responder: NUM_REGS read/write control words plus
// NUM_REGS read-only status words, one outstanding transaction per direction.
module axil_reg_slave
    import shell_axil_pkg::*;
#(
    parameter int          ADDR_W   = 12,
    parameter int          NUM_REGS = 16,
    parameter logic [31:0] CTRL_RST = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        s_axil_awaddr,
    input  logic                     s_axil_awvalid,
    output logic                     s_axil_awready,
    input  logic [31:0]              s_axil_wdata,
    input  logic [3:0]               s_axil_wstrb,
    input  logic                     s_axil_wvalid,
    output logic                     s_axil_wready,
    output logic [1:0]               s_axil_bresp,
    output logic                     s_axil_bvalid,
    input  logic                     s_axil_bready,
    input  logic [ADDR_W-1:0]        s_axil_araddr,
    input  logic                     s_axil_arvalid,
    output logic                     s_axil_arready,
    output logic [31:0]              s_axil_rdata,
    output logic [1:0]               s_axil_rresp,
    output logic                     s_axil_rvalid,
    input  logic                     s_axil_rready,
    output logic [NUM_REGS*32-1:0]   ctrl_out,
    output logic [NUM_REGS-1:0]      ctrl_wr_pulse,
    input  logic [NUM_REGS*32-1:0]   status_in
);

    localparam int IDX_W = ADDR_W - 3;

    wr_state_t                wr_state_q, wr_state_d;
    logic                     aw_held_q, aw_held_d;
    logic                     w_held_q, w_held_d;
    logic [ADDR_W-1:0]        awaddr_q, awaddr_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [3:0]               wstrb_q, wstrb_d;
    logic [1:0]               bresp_q, bresp_d;
    logic [NUM_REGS*32-1:0]   ctrl_q, ctrl_d;
    logic [NUM_REGS-1:0]      wr_pulse_q, wr_pulse_d;

    rd_state_t                rd_state_q, rd_state_d;
    logic [31:0]              rdata_q, rdata_d;
    logic [1:0]               rresp_q, rresp_d;

    logic                     aw_fire, w_fire, ar_fire;
    logic [ADDR_W-1:0]        wr_addr;
    logic [31:0]              wr_data;
    logic [3:0]               wr_strb;
    logic [IDX_W-1:0]         wr_idx, rd_idx;
    logic                     wr_ok, rd_ok;
    logic [31:0]              rd_word;
    logic                     unused_addr_lsbs;

    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
        return {{(32-IDX_W){1'b0}}, idx} < NUM_REGS;
    endfunction

    assign s_axil_awready = (wr_state_q == W_IDLE) && !aw_held_q;
    assign s_axil_wready  = (wr_state_q == W_IDLE) && !w_held_q;
    assign s_axil_bvalid  = (wr_state_q == W_RESP);
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = (rd_state_q == R_IDLE);
    assign s_axil_rvalid  = (rd_state_q == R_DATA);
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign ctrl_out       = ctrl_q;
    assign ctrl_wr_pulse  = wr_pulse_q;

    assign aw_fire = s_axil_awvalid && s_axil_awready;
    assign w_fire  = s_axil_wvalid && s_axil_wready;
    assign ar_fire = s_axil_arvalid && s_axil_arready;

    // A channel arriving this cycle is used directly so the commit lands on the
    // later handshake edge, giving one write per two cycles.
    assign wr_addr = aw_held_q ? awaddr_q : s_axil_awaddr;
    assign wr_data = w_held_q ? wdata_q : s_axil_wdata;
    assign wr_strb = w_held_q ? wstrb_q : s_axil_wstrb;
    assign wr_idx  = wr_addr[ADDR_W-2:2];
    assign wr_ok   = !wr_addr[ADDR_W-1] && idx_in_range(wr_idx);

    assign rd_idx  = s_axil_araddr[ADDR_W-2:2];
    assign rd_ok   = idx_in_range(rd_idx);
    assign unused_addr_lsbs = ^{wr_addr[1:0], s_axil_araddr[1:0]};

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        ctrl_d     = ctrl_q;
        wr_pulse_d = '0;
        unique case (wr_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_axil_awaddr;
                end
                if (w_fire) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axil_wdata;
                    wstrb_d  = s_axil_wstrb;
                end
                if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = W_RESP;
                    bresp_d    = wr_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (wr_ok && wr_idx == IDX_W'(i)) begin
                            ctrl_d[32*i +: 32] = apply_wstrb(ctrl_q[32*i +: 32], wr_data, wr_strb);
                            wr_pulse_d[i]      = 1'b1;
                        end
                    end
                end
            end
            W_RESP: begin
                if (s_axil_bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_word    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_word = s_axil_araddr[ADDR_W-1] ? status_in[32*i +: 32] : ctrl_q[32*i +: 32];
            end
        end
        unique case (rd_state_q)
            R_IDLE: begin
                if (ar_fire) begin
                    rd_state_d = R_DATA;
                    rdata_d    = rd_ok ? rd_word : 32'h0;
                    rresp_d    = rd_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                end
            end
            R_DATA: begin
                if (s_axil_rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= AXI_RESP_OKAY;
            ctrl_q     <= {NUM_REGS{CTRL_RST}};
            wr_pulse_q <= '0;
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= AXI_RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            ctrl_q     <= ctrl_d;
            wr_pulse_q <= wr_pulse_d;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

endmodule
